// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and size-aware access sequencer for the word-organised data memory
module dmem_arbiter #(
  parameter int MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [2:0]  c_funct3,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [2:0]  m_funct3,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_ack,
  output logic [31:0] m_rdata,
  output logic        m_err,
  output logic        d_r_en,
  output logic        d_w_en,
  output logic [31:0] d_add,
  output logic [31:0] data_in,
  input  logic [31:0] d_out
);
  typedef enum logic [2:0] {IDLE, READ, CAPT, MERGE, WRITE, DONE} state_t;
  localparam logic [29:0] LIMIT = 30'(MEM_WORDS);
  state_t state_q, state_d;
  logic port_q, port_d, last_q, last_d, we_q, we_d, err_q, err_d;
  logic [2:0] f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic gm, s_we, bad, done;
  logic [2:0] s_f3;
  logic [31:0] s_addr, s_wdata, lane, merged;
  logic [7:0] b;
  logic [15:0] h;
  logic [4:0] sh;
  always_comb begin
    gm = m_req & (~c_req | ~last_q);
    s_we = gm ? m_we : c_we;
    s_f3 = gm ? m_funct3 : c_funct3;
    s_addr = gm ? m_addr : c_addr;
    s_wdata = gm ? m_wdata : c_wdata;
    bad = !(s_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (s_we && s_f3[2]) ||
          (s_f3[1:0] == 2'b01 && s_addr[0]) || (s_f3 == 3'b010 && s_addr[1:0] != 2'b00) ||
          (s_addr[31:2] >= LIMIT);
    sh = {addr_q[1:0], 3'b000};
    b = 8'(d_out >> sh);
    h = addr_q[1] ? d_out[31:16] : d_out[15:0];
    lane = f3_q == 3'b000 ? {{24{b[7]}}, b} :
           f3_q == 3'b100 ? {24'b0, b} :
           f3_q == 3'b001 ? {{16{h[15]}}, h} :
           f3_q == 3'b101 ? {16'b0, h} : d_out;
    merged = f3_q[0] ? (d_out & ~(32'h0000FFFF << sh)) | ({16'b0, wdata_q[15:0]} << sh)
                     : (d_out & ~(32'h000000FF << sh)) | ({24'b0, wdata_q[7:0]} << sh);
    state_d = state_q;
    port_d = port_q;
    last_d = last_q;
    we_d = we_q;
    err_d = err_q;
    f3_d = f3_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (c_req || m_req) begin
        port_d = gm;
        we_d = s_we;
        f3_d = s_f3;
        addr_d = s_addr;
        wdata_d = s_wdata;
        rdata_d = '0;
        err_d = bad;
        state_d = bad ? DONE : (s_we && s_f3 == 3'b010) ? WRITE : READ;
      end
      READ:  state_d = we_q ? MERGE : CAPT;
      CAPT: begin
        rdata_d = lane;
        state_d = DONE;
      end
      MERGE: begin
        wdata_d = merged;
        state_d = WRITE;
      end
      WRITE: state_d = DONE;
      DONE: begin
        last_d = port_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      port_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      port_q <= port_d;
      we_q <= we_d;
      err_q <= err_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // rst gates the strobes combinationally so a write in flight is dropped in the reset cycle
  assign done = state_q == DONE && !rst;
  assign c_ack = done && !port_q;
  assign m_ack = done && port_q;
  assign c_rdata = c_ack ? rdata_q : '0;
  assign m_rdata = m_ack ? rdata_q : '0;
  assign c_err = c_ack && err_q;
  assign m_err = m_ack && err_q;
  assign d_r_en = state_q == READ && !rst;
  assign d_w_en = state_q == WRITE && !rst;
  assign d_add = (state_q == READ || state_q == WRITE) ? {2'b00, addr_q[31:2]} : '0;
  assign data_in = state_q == WRITE ? wdata_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a registered word memory model
module tb_dmem_arbiter;
  logic clk = 0, rst = 1;
  logic c_req = 0, c_we = 0, m_req = 0, m_we = 0;
  logic [2:0] c_funct3 = 0, m_funct3 = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, m_addr = 0, m_wdata = 0;
  logic c_ack, c_err, m_ack, m_err, d_r_en, d_w_en;
  logic [31:0] c_rdata, m_rdata, d_add, data_in;
  logic [31:0] d_out = 0;
  logic [31:0] mem [0:99];
  int errs = 0, checks = 0, rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_wadd = 0, last_wdata = 0;

  dmem_arbiter #(.MEM_WORDS(100)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
    .m_req(m_req), .m_we(m_we), .m_funct3(m_funct3), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .d_r_en(d_r_en), .d_w_en(d_w_en), .d_add(d_add), .data_in(data_in), .d_out(d_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (d_w_en) mem[d_add] <= data_in;
    if (d_r_en) d_out <= mem[d_add];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (d_r_en || d_w_en) chk("exclusive_en", {31'b0, d_r_en & d_w_en}, 32'd0);
    if (d_r_en) rd_cnt++;
    if (d_w_en) begin
      wr_cnt++;
      last_wadd = d_add;
      last_wdata = data_in;
    end
  end

  task automatic c_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat, input string tag);
    int n;
    @(posedge clk); #1;
    c_req = 1; c_we = we; c_funct3 = f3; c_addr = a; c_wdata = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!c_ack && n < 10);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_rdata"}, c_rdata, exp_rd);
    chk({tag, "_err"}, {31'b0, c_err}, {31'b0, exp_err});
    chk({tag, "_m_ack"}, {31'b0, m_ack}, 32'd0);
    c_req = 0;
  endtask

  initial begin
    int r0, w0, n;
    for (int i = 0; i < 100; i++) mem[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_c_ack", {31'b0, c_ack}, 0);
    chk("rst_m_ack", {31'b0, m_ack}, 0);
    chk("rst_en", {30'b0, d_r_en, d_w_en}, 0);
    chk("rst_d_add", d_add, 0);
    rst = 0;
    w0 = wr_cnt;
    c_op(1, 3'b010, 32'h10, 32'h12345678, 0, 0, 2, "sw10");
    chk("sw10_wadd", last_wadd, 4);
    chk("sw10_wdata", last_wdata, 32'h12345678);
    chk("sw10_wcnt", wr_cnt - w0, 1);
    c_op(0, 3'b010, 32'h10, 0, 32'h12345678, 0, 3, "lw10");
    r0 = rd_cnt; w0 = wr_cnt;
    c_op(1, 3'b000, 32'h12, 32'hAB, 0, 0, 4, "sb12");
    chk("sb12_rcnt", rd_cnt - r0, 1);
    chk("sb12_wcnt", wr_cnt - w0, 1);
    c_op(0, 3'b010, 32'h10, 0, 32'h12AB5678, 0, 3, "lw10b");
    c_op(1, 3'b010, 32'h20, 32'h00008080, 0, 0, 2, "sw20");
    c_op(0, 3'b000, 32'h20, 0, 32'hFFFFFF80, 0, 3, "lb20");
    c_op(0, 3'b100, 32'h20, 0, 32'h00000080, 0, 3, "lbu20");
    c_op(0, 3'b001, 32'h20, 0, 32'hFFFF8080, 0, 3, "lh20");
    c_op(0, 3'b101, 32'h20, 0, 32'h00008080, 0, 3, "lhu20");
    c_op(0, 3'b000, 32'h13, 0, 32'h00000012, 0, 3, "lb13");
    r0 = rd_cnt; w0 = wr_cnt;
    c_op(0, 3'b001, 32'h03, 0, 0, 1, 1, "lh03");
    c_op(1, 3'b010, 32'h02, 32'hDEAD, 0, 1, 1, "sw02");
    c_op(1, 3'b100, 32'h10, 32'h55, 0, 1, 1, "sb_f100");
    c_op(0, 3'b010, 32'd400, 0, 0, 1, 1, "lw_oor");
    c_op(0, 3'b011, 32'h10, 0, 0, 1, 1, "f011");
    chk("err_rcnt", rd_cnt - r0, 0);
    chk("err_wcnt", wr_cnt - w0, 0);
    c_op(0, 3'b010, 32'h10, 0, 32'h12AB5678, 0, 3, "lw10c");
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    c_we = 0; c_funct3 = 3'b010; c_addr = 32'h10;
    m_we = 0; m_funct3 = 3'b010; m_addr = 32'h20;
    c_req = 1; m_req = 1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!c_ack && !m_ack && n < 10);
      chk($sformatf("arb%0d_port", i), {30'b0, m_ack, c_ack}, (i % 2) ? 32'd2 : 32'd1);
      chk($sformatf("arb%0d_rdata", i), c_ack ? c_rdata : m_rdata, (i % 2) ? 32'h00008080 : 32'h12AB5678);
      chk($sformatf("arb%0d_idle", i), c_ack ? m_rdata : c_rdata, 0);
    end
    c_req = 0; m_req = 0;
    c_op(1, 3'b010, 32'h30, 32'h11111111, 0, 0, 2, "sw30");
    w0 = wr_cnt;
    @(posedge clk); #1;
    c_req = 1; c_we = 1; c_funct3 = 3'b001; c_addr = 32'h30; c_wdata = 32'hBEEF;
    @(posedge clk); #1;
    chk("sh30_read", {31'b0, d_r_en}, 1);
    @(posedge clk); #1;
    rst = 1; c_req = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid_ack", {31'b0, c_ack}, 0);
    chk("rst_mid_wen", {31'b0, d_w_en}, 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_mid_noack", {31'b0, c_ack | m_ack}, 0);
    end
    chk("rst_mid_wcnt", wr_cnt - w0, 0);
    c_op(0, 3'b010, 32'h30, 0, 32'h11111111, 0, 3, "lw30");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
